// File: rtl/avmm_rr_arbiter_if.sv
// Avalon-MM bundle between NUM_MASTERS requesters, the round-robin arbiter and one shared slave.
// The "slave" modport is the arbiter's view; "master" is the view of the surrounding masters and slave device.
interface avmm_rr_arbiter_if #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8
);
    logic [NUM_MASTERS*ADDR_W-1:0] m_address;
    logic [NUM_MASTERS-1:0]        m_read;
    logic [NUM_MASTERS-1:0]        m_write;
    logic [NUM_MASTERS*DATA_W-1:0] m_writedata;
    logic [NUM_MASTERS-1:0]        m_waitrequest;
    logic [DATA_W-1:0]             m_readdata;

    logic [ADDR_W-1:0]             s_address;
    logic                          s_read;
    logic                          s_write;
    logic [DATA_W-1:0]             s_writedata;
    logic                          s_waitrequest;
    logic [DATA_W-1:0]             s_readdata;

    modport master (
        output m_address, m_read, m_write, m_writedata,
        input  m_waitrequest, m_readdata,
        input  s_address, s_read, s_write, s_writedata,
        output s_waitrequest, s_readdata
    );

    modport slave (
        input  m_address, m_read, m_write, m_writedata,
        output m_waitrequest, m_readdata,
        output s_address, s_read, s_write, s_writedata,
        input  s_waitrequest, s_readdata
    );
endinterface

// File: rtl/avmm_rr_arbiter.sv
// Round-robin arbiter sharing one waitrequest-based Avalon-MM slave between NUM_MASTERS requesters,
// with a per-transfer wait-state timeout and sticky timeout/command error flags.
//
// state   | meaning
// IDLE    | no grant; all masters stalled; picks next requester after last_grant
// BUSY    | one master granted; its command is muxed onto the slave bus
module avmm_rr_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int TIMEOUT     = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    avmm_rr_arbiter_if.slave       bus,
    output logic [NUM_MASTERS-1:0] grant,
    output logic                   timeout_err,
    output logic                   cmd_err
);
    localparam int IDX_W = $clog2(NUM_MASTERS);
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } state_t;

    state_t               state;
    logic [IDX_W-1:0]     gnt_idx;
    logic [IDX_W-1:0]     last_grant;
    logic [CNT_W-1:0]     wait_cnt;

    logic [NUM_MASTERS-1:0] req;
    logic [IDX_W-1:0]       pick_idx;
    logic [IDX_W-1:0]       cand;
    logic                   pick_vld;

    logic                   busy;
    logic                   g_read;
    logic                   g_write;
    logic                   g_req;
    logic [ADDR_W-1:0]      g_addr;
    logic [DATA_W-1:0]      g_wdata;
    logic                   to_fire;

    assign req = bus.m_read | bus.m_write;

    // Scan downward so the candidate nearest to last_grant+1 is the one left standing.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int k = NUM_MASTERS; k >= 1; k--) begin
            cand = IDX_W'((int'(last_grant) + k) % NUM_MASTERS);
            if (req[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    assign busy    = (state == ST_BUSY);
    assign g_read  = bus.m_read[gnt_idx];
    assign g_write = bus.m_write[gnt_idx];
    assign g_req   = g_read | g_write;
    assign g_addr  = bus.m_address[gnt_idx*ADDR_W +: ADDR_W];
    assign g_wdata = bus.m_writedata[gnt_idx*DATA_W +: DATA_W];

    // Last permitted wait cycle: release the master ourselves instead of waiting on the slave.
    assign to_fire = busy & g_req & bus.s_waitrequest & (wait_cnt == CNT_LAST);

    always_comb begin
        bus.s_read        = busy & g_read;
        bus.s_write       = busy & g_write & ~g_read;
        bus.s_address     = busy ? g_addr  : '0;
        bus.s_writedata   = busy ? g_wdata : '0;
        bus.m_waitrequest = '1;
        bus.m_readdata    = '0;
        if (busy) begin
            bus.m_waitrequest[gnt_idx] = bus.s_waitrequest & ~to_fire;
            bus.m_readdata             = to_fire ? '1 : bus.s_readdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            grant       <= '0;
            gnt_idx     <= '0;
            last_grant  <= IDX_W'(NUM_MASTERS - 1);
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
            cmd_err     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_vld) begin
                        state    <= ST_BUSY;
                        gnt_idx  <= pick_idx;
                        grant    <= NUM_MASTERS'(1) << pick_idx;
                        wait_cnt <= '0;
                    end
                end
                ST_BUSY: begin
                    if (g_read && g_write) begin
                        cmd_err <= 1'b1;
                    end
                    if (!g_req) begin
                        // Abandoned transfer: the master keeps its place in the rotation.
                        state <= ST_IDLE;
                        grant <= '0;
                    end else if (!bus.s_waitrequest) begin
                        state      <= ST_IDLE;
                        grant      <= '0;
                        last_grant <= gnt_idx;
                    end else if (wait_cnt == CNT_LAST) begin
                        state       <= ST_IDLE;
                        grant       <= '0;
                        last_grant  <= gnt_idx;
                        timeout_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    grant <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_avmm_rr_arbiter.sv
// Bench for avmm_rr_arbiter: directed master traffic against a latency-programmable slave model,
// with a scoreboard of expected completions in grant order.
module tb_avmm_rr_arbiter;
    localparam int NM = 2;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic [NM-1:0] grant;
    logic          timeout_err;
    logic          cmd_err;

    always #5 clk = ~clk;

    avmm_rr_arbiter_if #(.NUM_MASTERS(NM), .ADDR_W(AW), .DATA_W(DW)) bus ();

    avmm_rr_arbiter #(.NUM_MASTERS(NM), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .grant       (grant),
        .timeout_err (timeout_err),
        .cmd_err     (cmd_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Slave model: read data is address ^ 0xCB; waitrequest drops once the strobe has waited slv_lat cycles.
    int slv_lat = 0;
    bit slv_hang = 1'b0;
    int slv_cnt = 0;

    always_comb begin
        bus.s_readdata    = bus.s_address ^ 8'hCB;
        bus.s_waitrequest = 1'b1;
        if ((bus.s_read || bus.s_write) && !slv_hang && slv_cnt >= slv_lat)
            bus.s_waitrequest = 1'b0;
    end

    always @(posedge clk) begin
        if ((bus.s_read || bus.s_write) && bus.s_waitrequest) slv_cnt <= slv_cnt + 1;
        else slv_cnt <= 0;
    end

    typedef struct {
        int         mst;
        logic [7:0] addr;
        logic [7:0] data;
        bit         is_rd;
    } exp_t;

    exp_t sb_q[$];
    int   wrl_cnt[NM];

    task automatic push(input int m, input bit rd, input logic [7:0] a, input logic [7:0] d);
        exp_t e;
        e.mst = m; e.addr = a; e.data = d; e.is_rd = rd;
        sb_q.push_back(e);
    endtask

    // Completion monitor: a requesting master seeing waitrequest low completes at the next edge.
    initial begin
        bit   exp_idle;
        exp_t e;
        exp_idle = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                if (exp_idle) begin
                    chk("idle_gap", grant, 0);
                    exp_idle = 1'b0;
                end
                for (int i = 0; i < NM; i++) begin
                    if (!bus.m_waitrequest[i]) wrl_cnt[i]++;
                    if ((bus.m_read[i] || bus.m_write[i]) && !bus.m_waitrequest[i]) begin
                        if (sb_q.size() == 0) begin
                            chk("sb_empty", sb_q.size(), 1);
                        end else begin
                            e = sb_q.pop_front();
                            chk("sb_mst", i, e.mst);
                            chk("sb_grant", grant, 32'(1) << i);
                            chk("sb_addr", bus.s_address, e.addr);
                            chk("sb_swrite", bus.s_write, !e.is_rd);
                            chk("sb_sread", bus.s_read, e.is_rd);
                            if (e.is_rd) chk("sb_rdata", bus.m_readdata, e.data);
                            else         chk("sb_wdata", bus.s_writedata, e.data);
                        end
                        exp_idle = 1'b1;
                    end
                end
            end
        end
    end

    task automatic xfer(input int m, input bit rd, input bit wr, input logic [7:0] a,
                        input logic [7:0] d, output int n);
        bus.m_read[m]             = rd;
        bus.m_write[m]            = wr;
        bus.m_address[m*AW +: AW] = a;
        bus.m_writedata[m*DW +: DW] = d;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.m_waitrequest[m] && n < 64);
        chk($sformatf("xfer_done_m%0d", m), bus.m_waitrequest[m], 0);
        @(posedge clk);
        #1;
        bus.m_read[m]  = 1'b0;
        bus.m_write[m] = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, na, nb, w0, w1;
        reset           = 1'b0;
        bus.m_read      = '0;
        bus.m_write     = '0;
        bus.m_address   = '0;
        bus.m_writedata = '0;

        repeat (2) @(negedge clk);
        chk("rst_grant", grant, 0);
        chk("rst_mwait", bus.m_waitrequest, 2'b11);
        chk("rst_rdata", bus.m_readdata, 0);
        chk("rst_sread", bus.s_read, 0);
        chk("rst_swrite", bus.s_write, 0);
        chk("rst_saddr", bus.s_address, 0);
        chk("rst_swdata", bus.s_writedata, 0);
        chk("rst_toerr", timeout_err, 0);
        chk("rst_cmderr", cmd_err, 0);
        @(posedge clk); #1 reset = 1'b1;

        // Contention from reset: m0, m1, m0, m1
        slv_lat = 1;
        push(0, 1'b1, 8'd3, 8'd200);
        push(1, 1'b0, 8'd7, 8'h22);
        push(0, 1'b0, 8'd5, 8'h11);
        push(1, 1'b1, 8'd9, 8'h09 ^ 8'hCB);
        fork
            begin int n0; xfer(0, 1'b1, 1'b0, 8'd3, 8'h00, n0); xfer(0, 1'b0, 1'b1, 8'd5, 8'h11, n0); end
            begin int n1; xfer(1, 1'b0, 1'b1, 8'd7, 8'h22, n1); xfer(1, 1'b1, 1'b0, 8'd9, 8'h00, n1); end
        join
        repeat (2) @(posedge clk); #1;

        // Single master write, slave ready two cycles after strobe
        slv_lat = 2;
        w0 = wrl_cnt[0];
        w1 = wrl_cnt[1];
        push(0, 1'b0, 8'd1, 8'd181);
        fork
            xfer(0, 1'b0, 1'b1, 8'd1, 8'd181, n);
            begin
                @(negedge clk);
                chk("t1_pre_grant", grant, 0);
                @(negedge clk);
                chk("t1_grant", grant, 2'b01);
                chk("t1_swrite", bus.s_write, 1);
                chk("t1_saddr", bus.s_address, 8'd1);
                chk("t1_swdata", bus.s_writedata, 8'd181);
            end
        join
        chk("t1_lat", n, 4);
        repeat (2) @(negedge clk);
        chk("t1_wait_low_m0", wrl_cnt[0] - w0, 1);
        chk("t1_wait_low_m1", wrl_cnt[1] - w1, 0);

        // Hung slave: forced release on 16th BUSY cycle
        @(posedge clk); #1;
        slv_hang = 1'b1;
        push(0, 1'b1, 8'h20, 8'hFF);
        xfer(0, 1'b1, 1'b0, 8'h20, 8'h00, n);
        chk("t3_lat", n, TO + 1);
        chk("t3_toerr", timeout_err, 1);
        slv_hang = 1'b0;
        slv_lat  = 0;
        push(1, 1'b0, 8'h30, 8'h5A);
        xfer(1, 1'b0, 1'b1, 8'h30, 8'h5A, n);
        chk("t3_next_lat", n, 2);

        // Read and write together from m1: read wins
        slv_lat = 1;
        push(1, 1'b1, 8'd4, 8'h04 ^ 8'hCB);
        xfer(1, 1'b1, 1'b1, 8'd4, 8'h55, n);
        chk("t4_cmderr", cmd_err, 1);

        // Withdrawal: m0 drops read mid-transfer and stays first in line
        slv_hang = 1'b1;
        bus.m_address[7:0] = 8'd6;
        bus.m_read[0] = 1'b1;
        repeat (2) @(negedge clk);
        chk("t5_grant", grant, 2'b01);
        @(posedge clk); #1 bus.m_read[0] = 1'b0;
        repeat (2) @(negedge clk);
        chk("t5_idle", grant, 0);
        chk("t5_cmderr_sticky", cmd_err, 1);
        slv_hang = 1'b0;
        slv_lat  = 0;
        @(posedge clk); #1;
        push(0, 1'b1, 8'h40, 8'h40 ^ 8'hCB);
        push(1, 1'b0, 8'h41, 8'h77);
        fork
            xfer(0, 1'b1, 1'b0, 8'h40, 8'h00, na);
            xfer(1, 1'b0, 1'b1, 8'h41, 8'h77, nb);
        join

        // Asynchronous reset while a write is on the slave bus
        @(posedge clk); #1;
        slv_hang = 1'b1;
        bus.m_address[7:0]   = 8'h50;
        bus.m_writedata[7:0] = 8'h99;
        bus.m_write[0]       = 1'b1;
        repeat (2) @(negedge clk);
        chk("t6_swrite_busy", bus.s_write, 1);
        chk("t6_toerr_sticky", timeout_err, 1);
        #2 reset = 1'b0;
        #1;
        chk("t6_swrite", bus.s_write, 0);
        chk("t6_grant", grant, 0);
        chk("t6_mwait", bus.m_waitrequest, 2'b11);
        chk("t6_toerr", timeout_err, 0);
        chk("t6_cmderr", cmd_err, 0);
        bus.m_write[0] = 1'b0;
        slv_hang = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        push(0, 1'b0, 8'h60, 8'h01);
        push(1, 1'b0, 8'h61, 8'h02);
        fork
            xfer(1, 1'b0, 1'b1, 8'h61, 8'h02, nb);
            xfer(0, 1'b0, 1'b1, 8'h60, 8'h01, na);
        join

        repeat (2) @(negedge clk);
        chk("sb_left", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
